// File: rtl/rtc_digit_loader.sv
// Scans ten RTC registers into a shadow bank over the bus read handshake and commits them
// to the screen digit outputs in a single cycle on a frame tick, so no digit tears mid-frame.

module rtc_bcd_nib (
  input  logic [3:0] raw,
  output logic [3:0] fixed,
  output logic       err
);
  assign err   = (raw > 4'd9);
  assign fixed = err ? 4'd0 : raw;
endmodule

module rtc_digit_loader #(
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] ADDR_TIME   = 8'h21,
  parameter logic [7:0] ADDR_TIMER  = 8'h41
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       frame_tick,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [3:0] digit0_HH,   digit1_HH,
  output logic [3:0] digit0_MM,   digit1_MM,
  output logic [3:0] digit0_SS,   digit1_SS,
  output logic [3:0] digit0_DAY,  digit1_DAY,
  output logic [3:0] digit0_MES,  digit1_MES,
  output logic [3:0] digit0_YEAR, digit1_YEAR,
  output logic [3:0] digit0_HH_T, digit1_HH_T,
  output logic [3:0] digit0_MM_T, digit1_MM_T,
  output logic [3:0] digit0_SS_T, digit1_SS_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana,
  output logic       data_valid,
  output logic       bcd_error,
  output logic       rd_timeout,
  output logic       busy
);
  localparam int NUM_DIG = 9;
  localparam int TW      = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, GAP, WAIT_FRAME, COMMIT} state_t;
  state_t state, state_nx;

  logic [3:0]                   idx, slot;
  logic                         pending, timeout;
  logic [TW-1:0]                tcnt;
  // shadow holds only the nine digit-pair bytes; weekday and AM/PM live beside it
  logic [NUM_DIG-1:0][7:0]      shadow, dig_fix, dig_q;
  logic [NUM_DIG-1:0][1:0]      nib_err;
  logic [2:0]                   wd_sh;
  logic                         am_pm_sh;

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    return (i < 4'd7) ? ADDR_TIME + 8'(i) : ADDR_TIMER + 8'(i - 4'd7);
  endfunction

  function automatic logic [7:0] mask_of(input logic [3:0] i);
    logic [7:0] m;
    m = 8'h00;
    case (i)
      4'd0, 4'd1, 4'd7, 4'd8: m = 8'h7F;
      4'd2, 4'd3, 4'd9:       m = 8'h3F;
      4'd4:                   m = 8'h1F;
      4'd5:                   m = 8'hFF;
      default:                m = 8'h00;
    endcase
    return m;
  endfunction

  assign slot    = (idx > 4'd6) ? idx - 4'd1 : idx;
  assign timeout = (state == REQ) && !rd_ack && (tcnt == TW'(ACK_TIMEOUT - 1));
  assign rd_req  = (state == REQ);
  assign rd_addr = (state == REQ) ? addr_of(idx) : 8'h00;
  assign busy    = (state != IDLE);

  for (genvar j = 0; j < NUM_DIG; j++) begin : g_dig
    for (genvar k = 0; k < 2; k++) begin : g_nib
      rtc_bcd_nib u_nib (
        .raw   (shadow[j][4*k +: 4]),
        .fixed (dig_fix[j][4*k +: 4]),
        .err   (nib_err[j][k])
      );
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (refresh_tick || pending) state_nx = REQ;
      REQ:        if (rd_ack) state_nx = GAP;
                  else if (timeout) state_nx = IDLE;
      GAP:        state_nx = (idx == 4'd9) ? WAIT_FRAME : REQ;
      WAIT_FRAME: if (frame_tick) state_nx = COMMIT;
      COMMIT:     state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx        <= '0;
      pending    <= 1'b0;
      tcnt       <= '0;
      shadow     <= '0;
      wd_sh      <= '0;
      am_pm_sh   <= 1'b0;
      dig_q      <= '0;
      AM_PM      <= 1'b0;
      dia_semana <= '0;
      data_valid <= 1'b0;
      bcd_error  <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= timeout;
      tcnt       <= (state == REQ) ? tcnt + 1'b1 : '0;
      // IDLE always leaves when pending is set, so clearing here is the hand-off
      if (state == IDLE)     pending <= 1'b0;
      else if (refresh_tick) pending <= 1'b1;
      if (state == REQ && rd_ack) begin
        if (idx == 4'd6) wd_sh <= rd_data[2:0];
        else             shadow[slot] <= rd_data & mask_of(idx);
        if (idx == 4'd2) am_pm_sh <= rd_data[7];
      end
      if (state == GAP && idx != 4'd9) idx <= idx + 4'd1;
      if (timeout || state == COMMIT)  idx <= '0;
      if (state == COMMIT) begin
        dig_q      <= dig_fix;
        AM_PM      <= am_pm_sh;
        dia_semana <= wd_sh;
        data_valid <= 1'b1;
        bcd_error  <= |nib_err;
      end
    end
  end

  assign {digit1_SS,   digit0_SS}   = dig_q[0];
  assign {digit1_MM,   digit0_MM}   = dig_q[1];
  assign {digit1_HH,   digit0_HH}   = dig_q[2];
  assign {digit1_DAY,  digit0_DAY}  = dig_q[3];
  assign {digit1_MES,  digit0_MES}  = dig_q[4];
  assign {digit1_YEAR, digit0_YEAR} = dig_q[5];
  assign {digit1_SS_T, digit0_SS_T} = dig_q[6];
  assign {digit1_MM_T, digit0_MM_T} = dig_q[7];
  assign {digit1_HH_T, digit0_HH_T} = dig_q[8];
endmodule

// File: tb/tb_rtc_digit_loader.sv
// Scoreboard bench: each scan pushes its expected committed set; a monitor pops on every
// busy->idle transition and otherwise requires outputs to hold the last committed set.

module tb_rtc_digit_loader;
  localparam int ACK_T = 255;

  typedef struct packed {
    logic       timeout;
    logic [3:0] hh1, hh0, mm1, mm0, ss1, ss0, day1, day0, mes1, mes0, yr1, yr0;
    logic [3:0] hht1, hht0, mmt1, mmt0, sst1, sst0;
    logic       am;
    logic [2:0] dia;
    logic       valid;
    logic       berr;
  } exp_t;

  localparam exp_t EXP_A  = {1'b0, 4'd1,4'd1, 4'd3,4'd7, 4'd4,4'd5, 4'd2,4'd8, 4'd1,4'd2, 4'd1,4'd6,
                             4'd0,4'd2, 4'd1,4'd0, 4'd0,4'd5, 1'b1, 3'd3, 1'b1, 1'b0};
  localparam exp_t EXP_B  = {1'b0, 4'd1,4'd2, 4'd5,4'd9, 4'd5,4'd9, 4'd3,4'd1, 4'd1,4'd2, 4'd9,4'd9,
                             4'd1,4'd1, 4'd4,4'd5, 4'd3,4'd0, 1'b0, 3'd6, 1'b1, 1'b0};
  localparam exp_t EXP_E  = {1'b0, 4'd1,4'd2, 4'd7,4'd0, 4'd5,4'd9, 4'd3,4'd1, 4'd1,4'd2, 4'd9,4'd9,
                             4'd1,4'd1, 4'd4,4'd5, 4'd3,4'd0, 1'b0, 3'd6, 1'b1, 1'b1};
  localparam exp_t EXP_BT = {1'b1, 4'd1,4'd2, 4'd5,4'd9, 4'd5,4'd9, 4'd3,4'd1, 4'd1,4'd2, 4'd9,4'd9,
                             4'd1,4'd1, 4'd4,4'd5, 4'd3,4'd0, 1'b0, 3'd6, 1'b1, 1'b0};

  logic clock = 1'b0, reset = 1'b0, refresh_tick = 1'b0, frame_tick = 1'b0;
  logic rd_req, rd_ack = 1'b0;
  logic [7:0] rd_addr, rd_data = 8'h00;
  logic [3:0] digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS;
  logic [3:0] digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR;
  logic [3:0] digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T;
  logic AM_PM, data_valid, bcd_error, rd_timeout, busy;
  logic [2:0] dia_semana;

  rtc_digit_loader #(.ACK_TIMEOUT(ACK_T), .ADDR_TIME(8'h21), .ADDR_TIMER(8'h41)) dut (
    .clock(clock), .reset(reset), .refresh_tick(refresh_tick), .frame_tick(frame_tick),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .digit0_HH(digit0_HH), .digit1_HH(digit1_HH), .digit0_MM(digit0_MM), .digit1_MM(digit1_MM),
    .digit0_SS(digit0_SS), .digit1_SS(digit1_SS), .digit0_DAY(digit0_DAY), .digit1_DAY(digit1_DAY),
    .digit0_MES(digit0_MES), .digit1_MES(digit1_MES), .digit0_YEAR(digit0_YEAR), .digit1_YEAR(digit1_YEAR),
    .digit0_HH_T(digit0_HH_T), .digit1_HH_T(digit1_HH_T), .digit0_MM_T(digit0_MM_T), .digit1_MM_T(digit1_MM_T),
    .digit0_SS_T(digit0_SS_T), .digit1_SS_T(digit1_SS_T), .AM_PM(AM_PM), .dia_semana(dia_semana),
    .data_valid(data_valid), .bcd_error(bcd_error), .rd_timeout(rd_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  exp_t act_v;
  assign act_v = {rd_timeout, digit1_HH, digit0_HH, digit1_MM, digit0_MM, digit1_SS, digit0_SS,
                  digit1_DAY, digit0_DAY, digit1_MES, digit0_MES, digit1_YEAR, digit0_YEAR,
                  digit1_HH_T, digit0_HH_T, digit1_MM_T, digit0_MM_T, digit1_SS_T, digit0_SS_T,
                  AM_PM, dia_semana, data_valid, bcd_error};

  int n_pass = 0, n_total = 0;
  exp_t sb[$];
  exp_t cur = '0, popped;
  logic mon_en = 1'b0, busy_q = 1'b0, toggle_ack = 1'b0;
  logic [7:0] no_ack_addr = 8'h00;
  logic [7:0] mem [256];

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] x);
    n_total++;
    if (a === x) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", name, a, x);
  endtask

  function automatic logic [7:0] tb_addr(input int i);
    return (i < 7) ? 8'(8'h21 + i) : 8'(8'h41 + i - 7);
  endfunction

  task automatic load(input logic [79:0] v);
    for (int i = 0; i < 10; i++) mem[tb_addr(i)] = v[79-8*i -: 8];
  endtask

  // bus controller model: acks on the second cycle of each request
  int wcnt = 0;
  always @(negedge clock) begin
    if (toggle_ack) rd_ack = ~rd_ack;
    else begin
      rd_ack = 1'b0;
      if (rd_req && rd_addr != no_ack_addr) begin
        if (wcnt == 1) begin rd_ack = 1'b1; rd_data = mem[rd_addr]; wcnt = 0; end
        else wcnt++;
      end else wcnt = 0;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (busy_q && !busy) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_commit act=%0h exp=none", act_v);
        end else begin
          popped = sb.pop_front();
          chk("commit", act_v, popped);
          cur = popped;
          cur.timeout = 1'b0;
        end
      end else chk("hold", act_v, cur);
      busy_q = busy;
    end
  end

  task automatic pulse_refresh();
    refresh_tick = 1'b1; @(negedge clock); refresh_tick = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1; @(negedge clock); frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clock); n++; end
    chk("idle_reached", {127'b0, busy}, 128'b0);
  endtask

  task automatic do_scan(input exp_t e);
    sb.push_back(e);
    pulse_refresh();
    repeat (40) @(negedge clock);
    pulse_frame();
    wait_idle(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset held with ack toggling
    toggle_ack = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_outputs", act_v, 128'b0);
    chk("reset_rd_req",  {127'b0, rd_req}, 128'b0);
    chk("reset_busy",    {127'b0, busy}, 128'b0);
    chk("reset_rd_addr", {120'b0, rd_addr}, 128'b0);
    toggle_ack = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
    repeat (3) @(negedge clock);

    // full scan, stray frame_tick mid-scan, commit well after the scan
    load({8'h45, 8'h37, 8'h91, 8'h28, 8'h12, 8'h16, 8'h03, 8'h05, 8'h10, 8'h02});
    sb.push_back(EXP_A);
    pulse_refresh();
    chk("req_latency", {119'b0, rd_req, rd_addr}, {119'b0, 1'b1, 8'h21});
    repeat (8) @(negedge clock);
    pulse_frame();
    repeat (70) @(negedge clock);
    chk("wait_frame_a", {126'b0, busy, rd_req}, {126'b0, 2'b10});
    pulse_frame();
    wait_idle(20);

    // frame_tick on the last ack is ignored; source changes while waiting are not seen
    load({8'h59, 8'h59, 8'h12, 8'h31, 8'h12, 8'h99, 8'h06, 8'h30, 8'h45, 8'h11});
    sb.push_back(EXP_B);
    pulse_refresh();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clock); #1;
      if (rd_ack && rd_addr == 8'h43) found = 1'b1;
    end
    chk("last_ack_seen", {127'b0, found}, {127'b0, 1'b1});
    frame_tick = 1'b1; @(negedge clock); frame_tick = 1'b0;
    load({8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h01, 8'h66, 8'h77, 8'h08});
    repeat (1000) @(negedge clock);
    chk("wait_frame_b", {126'b0, busy, rd_req}, {126'b0, 2'b10});
    pulse_frame();
    wait_idle(20);

    // bad BCD nibble, then a clean scan clears bcd_error
    load({8'h59, 8'h7A, 8'h12, 8'h31, 8'h12, 8'h99, 8'h06, 8'h30, 8'h45, 8'h11});
    do_scan(EXP_E);
    mem[8'h22] = 8'h59;
    do_scan(EXP_B);

    // no ack at DAY: abort after ACK_T cycles, outputs keep last set
    no_ack_addr = 8'h24;
    sb.push_back(EXP_BT);
    pulse_refresh();
    n = 0;
    while (!(rd_req && rd_addr == 8'h24) && n < 200) begin @(negedge clock); n++; end
    chk("timeout_req_seen", {127'b0, rd_req}, {127'b0, 1'b1});
    n = 0;
    while (!rd_timeout && n < 400) begin @(negedge clock); n++; end
    chk("timeout_latency", 128'(n), 128'(ACK_T));
    chk("timeout_idle", {126'b0, busy, rd_req}, 128'b0);
    no_ack_addr = 8'h00;
    repeat (3) @(negedge clock);

    // three refresh ticks mid-scan merge into one extra scan
    sb.push_back(EXP_B);
    pulse_refresh();
    repeat (3) begin repeat (4) @(negedge clock); pulse_refresh(); end
    repeat (30) @(negedge clock);
    pulse_frame();
    wait_idle(20);
    chk("pending_idle_gap", {127'b0, rd_req}, 128'b0);
    @(negedge clock);
    chk("pending_rescan", {119'b0, rd_req, rd_addr}, {119'b0, 1'b1, 8'h21});
    sb.push_back(EXP_B);
    repeat (40) @(negedge clock);
    pulse_frame();
    wait_idle(20);
    repeat (5) @(negedge clock);
    chk("pending_single", {126'b0, busy, rd_req}, 128'b0);

    chk("scoreboard_drained", 128'(sb.size()), 128'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
